// File: rtl/tri_issue_queue_pkg.sv
// Shared types and sizes for the rast triangle-input issue queue.
// Coordinates and colors are fixed-point words that pass through untouched
// (10 fraction bits), so no fraction-width parameter is needed here.
package tri_issue_queue_pkg;

  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [3:0] SUBSAMPLE_RST = 4'b1000;

  typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]                  color_t;

  // One queued triangle: geometry plus its color.
  typedef struct packed {
    tri_t   tri_d;
    color_t color_d;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [0:0] {
    CFG_IDLE = 1'b0,
    CFG_WAIT = 1'b1
  } cfg_state_e;

  // Occupancy after one cycle of optional push and pop.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic push,
                                                  input logic pop);
    logic [CNT_W-1:0] res;
    case ({push, pop})
      2'b10:   res = cnt + CNT_W'(1);
      2'b01:   res = cnt - CNT_W'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tri_issue_queue_if.sv
// Triangle stream bundle: upstream valid/ready push side and the R10 rast side.
interface tri_issue_queue_if;
  import tri_issue_queue_pkg::*;

  logic   in_valid;
  logic   in_ready;
  tri_t   in_tri;
  color_t in_color;
  tri_t   tri_R10S;
  color_t color_R10U;
  logic   validTri_R10H;
  logic   halt_RnnnnL;

  // Producer / rast environment side.
  modport master (
    output in_valid, in_tri, in_color, halt_RnnnnL,
    input  in_ready, tri_R10S, color_R10U, validTri_R10H
  );

  // Issue queue side.
  modport slave (
    input  in_valid, in_tri, in_color, halt_RnnnnL,
    output in_ready, tri_R10S, color_R10U, validTri_R10H
  );

endinterface

// File: rtl/tri_issue_queue_fifo.sv
// DEPTH-entry synchronous FIFO holding triangles waiting for the R10 register.
// Head data is read combinationally so the top can pop straight into R10.
module tri_issue_queue_fifo
  import tri_issue_queue_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_s;
  logic               pop_s;

  // Guard the handshake so a stray push at full or pop at empty cannot corrupt state.
  always_comb begin
    push_s = push & ~full;
    pop_s  = pop & ~empty;
  end

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign count = count_r;
  assign rdata = mem_r[rd_ptr_r];

  // Storage write port; entries are cleared on reset so no stale triangle is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= next_count(count_r, push_s, pop_s);
    end
  end

endmodule

// File: rtl/tri_issue_queue.sv
// Transmit side of the rast triangle input: queues upstream triangles, presents
// them on the R10 register under halt backpressure, and swaps the screen /
// subsample configuration only while the pipe input is fully drained.
module tri_issue_queue
  import tri_issue_queue_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  tri_issue_queue_if.slave    bus,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2*SIGFIG-1:0] cfg_screen,
  input  logic [3:0]          cfg_subsample,
  output logic [2*SIGFIG-1:0] screen_RnnnnS,
  output logic [3:0]          subSample_RnnnnU,
  output logic [31:0]         issued_cnt
);

  cfg_state_e          state_r;
  cfg_state_e          state_nxt_s;
  logic                cfg_load_s;
  logic                cfg_ready_r;
  logic [2*SIGFIG-1:0] screen_r;
  logic [3:0]          subsample_r;
  logic [31:0]         issued_cnt_r;

  logic                in_ready_r;
  logic                in_ready_nxt_s;
  logic                valid_r;
  logic                valid_nxt_s;
  entry_t              r10_r;
  entry_t              r10_nxt_s;

  logic                push_s;
  logic                xfer_s;
  logic                load_en_s;
  logic                bypass_s;
  logic                fifo_push_s;
  logic                fifo_pop_s;
  entry_t              in_entry_s;
  entry_t              fifo_rdata_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic [CNT_W-1:0]    count_nxt_s;

  tri_issue_queue_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata (in_entry_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Handshake decode: R10 can reload when empty or draining; an empty queue is bypassed.
  always_comb begin
    in_entry_s.tri_d   = bus.in_tri;
    in_entry_s.color_d = bus.in_color;
    push_s      = bus.in_valid & in_ready_r;
    xfer_s      = valid_r & bus.halt_RnnnnL;
    load_en_s   = ~valid_r | bus.halt_RnnnnL;
    bypass_s    = push_s & load_en_s & fifo_empty_s;
    fifo_pop_s  = load_en_s & ~fifo_empty_s;
    fifo_push_s = push_s & ~bypass_s & ~fifo_full_s;
    count_nxt_s = next_count(fifo_count_s, fifo_push_s, fifo_pop_s);
  end

  // R10 next value: queue head first, else the bypassed input, else go idle.
  always_comb begin
    r10_nxt_s   = r10_r;
    valid_nxt_s = valid_r;
    if (load_en_s) begin
      if (!fifo_empty_s) begin
        r10_nxt_s   = fifo_rdata_s;
        valid_nxt_s = 1'b1;
      end else if (bypass_s) begin
        r10_nxt_s   = in_entry_s;
        valid_nxt_s = 1'b1;
      end else begin
        valid_nxt_s = 1'b0;
      end
    end else begin
      r10_nxt_s   = r10_r;
      valid_nxt_s = valid_r;
    end
  end

  // Config FSM next state; the cfg_ready guard stops a held cfg_valid from re-triggering.
  always_comb begin
    state_nxt_s = state_r;
    cfg_load_s  = 1'b0;
    case (state_r)
      CFG_IDLE: begin
        if (cfg_valid && !cfg_ready_r) begin
          state_nxt_s = CFG_WAIT;
        end else begin
          state_nxt_s = CFG_IDLE;
        end
      end
      CFG_WAIT: begin
        if (fifo_empty_s && !valid_r && bus.halt_RnnnnL) begin
          cfg_load_s  = 1'b1;
          state_nxt_s = CFG_IDLE;
        end else begin
          state_nxt_s = CFG_WAIT;
        end
      end
      default: begin
        state_nxt_s = CFG_IDLE;
      end
    endcase
    in_ready_nxt_s = (state_nxt_s == CFG_IDLE) && (count_nxt_s < CNT_W'(DEPTH));
  end

  // Config FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= CFG_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // R10 output register and registered upstream ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r10_r      <= '{tri_d: '0, color_d: '0};
      valid_r    <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      r10_r      <= r10_nxt_s;
      valid_r    <= valid_nxt_s;
      in_ready_r <= in_ready_nxt_s;
    end
  end

  // Screen/subsample registers, the one-cycle accept pulse and the transfer counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_ready_r  <= 1'b0;
      screen_r     <= {(2*SIGFIG){1'b0}};
      subsample_r  <= SUBSAMPLE_RST;
      issued_cnt_r <= 32'd0;
    end else begin
      cfg_ready_r <= cfg_load_s;
      if (cfg_load_s) begin
        screen_r    <= cfg_screen;
        subsample_r <= cfg_subsample;
      end
      if (xfer_s) begin
        issued_cnt_r <= issued_cnt_r + 32'd1;
      end
    end
  end

  assign bus.in_ready      = in_ready_r;
  assign bus.tri_R10S      = r10_r.tri_d;
  assign bus.color_R10U    = r10_r.color_d;
  assign bus.validTri_R10H = valid_r;
  assign cfg_ready         = cfg_ready_r;
  assign screen_RnnnnS     = screen_r;
  assign subSample_RnnnnU  = subsample_r;
  assign issued_cnt        = issued_cnt_r;

endmodule

// File: tb/tb_tri_issue_queue.sv
// Self-checking bench for tri_issue_queue: a scoreboard queue receives every
// accepted triangle and a negedge monitor compares each rast transfer in order.
module tb_tri_issue_queue;
  import tri_issue_queue_pkg::*;

  logic                clk;
  logic                rst;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [2*SIGFIG-1:0] cfg_screen;
  logic [3:0]          cfg_subsample;
  logic [2*SIGFIG-1:0] screen_RnnnnS;
  logic [3:0]          subSample_RnnnnU;
  logic [31:0]         issued_cnt;

  int     n_tests;
  int     n_fail;
  entry_t exp_q[$];
  entry_t sb_exp;
  entry_t sb_got;

  tri_issue_queue_if bus();

  tri_issue_queue dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_screen       (cfg_screen),
    .cfg_subsample    (cfg_subsample),
    .screen_RnnnnS    (screen_RnnnnS),
    .subSample_RnnnnU (subSample_RnnnnU),
    .issued_cnt       (issued_cnt)
  );

  always #5 clk = ~clk;

  function automatic entry_t rand_entry();
    entry_t e;
    for (int k = 0; k < ENTRY_W / 32; k++) begin
      e[k*32 +: 32] = $urandom();
    end
    return e;
  endfunction

  // Scoreboard: every rast transfer must match the oldest accepted triangle.
  always @(negedge clk) begin
    if (rst && bus.validTri_R10H && bus.halt_RnnnnL) begin
      n_tests++;
      sb_got.tri_d   = bus.tri_R10S;
      sb_got.color_d = bus.color_R10U;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got %h with nothing expected", sb_got);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_order: got %h expected %h", sb_got, sb_exp);
        end
      end
    end
  end

  // Offer one triangle until accepted; records it in the scoreboard on acceptance.
  task automatic push_item(input entry_t e);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_tri   = e.tri_d;
    bus.in_color = e.color_d;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0, required 1 within 40 cycles");
    end
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0 && !bus.validTri_R10H) break;
      @(posedge clk); #1;
    end
    n_tests++;
    if (exp_q.size() != 0 || bus.validTri_R10H !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d left, valid=%b, required 0 left valid=0", name, exp_q.size(), bus.validTri_R10H);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({bus.validTri_R10H, bus.in_ready, cfg_ready, subSample_RnnnnU, screen_RnnnnS, issued_cnt}
        !== {1'b0, 1'b1, 1'b0, 4'b1000, 48'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: v=%b rdy=%b cr=%b sub=%b scr=%h cnt=%h required 0 1 0 1000 0 0",
               bus.validTri_R10H, bus.in_ready, cfg_ready, subSample_RnnnnU, screen_RnnnnS, issued_cnt);
    end
    n_tests++;
    if ({bus.tri_R10S, bus.color_R10U} !== {216'h0, 72'h0}) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {bus.tri_R10S, bus.color_R10U});
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.validTri_R10H, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_release: v/rdy=%b required 01", {bus.validTri_R10H, bus.in_ready});
    end
  endtask

  task automatic test_basic();
    entry_t e;
    bus.halt_RnnnnL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = rand_entry();
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_ready%0d: got %b required 1", i, bus.in_ready);
      end
      exp_q.push_back(e);
      bus.in_valid = 1'b1; bus.in_tri = e.tri_d; bus.in_color = e.color_d;
      @(posedge clk); #1;
      n_tests++;
      if ({bus.validTri_R10H, bus.tri_R10S, bus.color_R10U} !== {1'b1, e.tri_d, e.color_d}) begin
        n_fail++;
        $display("FAIL basic_lat%0d: valid=%b tri=%h required valid=1 tri=%h", i, bus.validTri_R10H, bus.tri_R10S, e.tri_d);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.validTri_R10H, issued_cnt} !== {1'b0, 32'd3}) begin
      n_fail++;
      $display("FAIL basic_cnt: valid=%b cnt=%0d required valid=0 cnt=3", bus.validTri_R10H, issued_cnt);
    end
    wait_drain("basic");
  endtask

  task automatic test_stall();
    entry_t b;
    b = rand_entry();
    bus.halt_RnnnnL = 1'b0;
    push_item(b);
    for (int i = 0; i < DEPTH; i++) push_item(rand_entry());
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_tri = rand_entry().tri_d;
      @(posedge clk); #1;
      n_tests++;
      if ({bus.validTri_R10H, bus.in_ready, bus.tri_R10S, bus.color_R10U} !== {1'b1, 1'b0, b.tri_d, b.color_d}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b rdy=%b tri=%h required valid=1 rdy=0 tri=%h",
                 i, bus.validTri_R10H, bus.in_ready, bus.tri_R10S, b.tri_d);
      end
    end
    bus.in_valid = 1'b0;
    bus.halt_RnnnnL = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_cfg();
    bit seen;
    bus.halt_RnnnnL = 1'b0;
    for (int i = 0; i < 3; i++) push_item(rand_entry());
    cfg_valid = 1'b1; cfg_screen = {24'h000100, 24'h000200}; cfg_subsample = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({cfg_ready, bus.in_ready, subSample_RnnnnU} !== {1'b0, 1'b0, 4'b1000}) begin
        n_fail++;
        $display("FAIL cfg_wait%0d: cr=%b rdy=%b sub=%b required 0 0 1000", i, cfg_ready, bus.in_ready, subSample_RnnnnU);
      end
    end
    bus.halt_RnnnnL = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (cfg_ready) seen = 1'b1;
    end
    n_tests++;
    if (!seen || exp_q.size() != 0 || bus.validTri_R10H !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_accept: seen=%b left=%0d valid=%b required seen=1 left=0 valid=0", seen, exp_q.size(), bus.validTri_R10H);
    end
    n_tests++;
    if ({screen_RnnnnS, subSample_RnnnnU} !== {48'h000100000200, 4'b0100}) begin
      n_fail++;
      $display("FAIL cfg_values: scr=%h sub=%b required 000100000200 0100", screen_RnnnnS, subSample_RnnnnU);
    end
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({cfg_ready, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL cfg_done: cr/rdy=%b required 01", {cfg_ready, bus.in_ready});
    end
  endtask

  task automatic test_simul();
    bus.halt_RnnnnL = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_item(rand_entry());
    bus.halt_RnnnnL = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_item(rand_entry());
      n_tests++;
      if (dut.fifo_count_s !== CNT_W'(DEPTH - 1)) begin
        n_fail++;
        $display("FAIL simul_count%0d: got %0d required %0d", i, dut.fifo_count_s, DEPTH - 1);
      end
    end
    wait_drain("simul");
  endtask

  task automatic test_reset_mid();
    entry_t f;
    bus.halt_RnnnnL = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_item(rand_entry());
    rst = 1'b0;
    #1;
    exp_q.delete();
    n_tests++;
    if ({bus.validTri_R10H, bus.in_ready, cfg_ready, subSample_RnnnnU, screen_RnnnnS, issued_cnt}
        !== {1'b0, 1'b1, 1'b0, 4'b1000, 48'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL rstmid_ctrl: v=%b rdy=%b cr=%b sub=%b scr=%h cnt=%h required 0 1 0 1000 0 0",
               bus.validTri_R10H, bus.in_ready, cfg_ready, subSample_RnnnnU, screen_RnnnnS, issued_cnt);
    end
    n_tests++;
    if ({bus.tri_R10S, bus.color_R10U} !== {216'h0, 72'h0}) begin
      n_fail++;
      $display("FAIL rstmid_data: got %h required 0", {bus.tri_R10S, bus.color_R10U});
    end
    @(negedge clk); rst = 1'b1; bus.halt_RnnnnL = 1'b1;
    @(posedge clk); #1;
    f = rand_entry();
    exp_q.push_back(f);
    bus.in_valid = 1'b1; bus.in_tri = f.tri_d; bus.in_color = f.color_d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_tests++;
    if ({bus.validTri_R10H, bus.tri_R10S} !== {1'b1, f.tri_d}) begin
      n_fail++;
      $display("FAIL rstmid_first: valid=%b tri=%h required valid=1 tri=%h", bus.validTri_R10H, bus.tri_R10S, f.tri_d);
    end
    wait_drain("rstmid");
  endtask

  task automatic test_wrap();
    entry_t g;
    force dut.issued_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.issued_cnt_r;
    n_tests++;
    if (issued_cnt !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_preset: got %h required ffffffff", issued_cnt);
    end
    @(posedge clk); #1;
    bus.halt_RnnnnL = 1'b1;
    g = rand_entry();
    push_item(g);
    @(posedge clk); #1;
    n_tests++;
    if (issued_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_cnt: got %h required 00000000", issued_cnt);
    end
    wait_drain("wrap");
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    clk = 1'b0; rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_tri = '0; bus.in_color = '0; bus.halt_RnnnnL = 1'b1;
    cfg_valid = 1'b0; cfg_screen = '0; cfg_subsample = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_cfg();
    test_simul();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
